// File: rtl/hpi_arb_pkg.sv
// Shared types and constants for the two-requester EZ-OTG HPI access arbiter.
package hpi_arb_pkg;

  localparam int unsigned HPI_DW = 16;
  localparam int unsigned HPI_AW = 2;
  localparam int unsigned CNT_W  = 4;

  localparam logic [HPI_AW-1:0] HPI_DATA    = 2'b00;
  localparam logic [HPI_AW-1:0] HPI_MAILBOX = 2'b01;
  localparam logic [HPI_AW-1:0] HPI_ADDR    = 2'b10;
  localparam logic [HPI_AW-1:0] HPI_STATUS  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  typedef struct packed {
    logic              we;
    logic [HPI_AW-1:0] addr;
    logic [HPI_DW-1:0] wdata;
  } hpi_cmd_t;

  // Phase counters count down to zero, so a phase of N cycles loads N-1.
  function automatic logic [CNT_W-1:0] cnt_load(input int unsigned cyc);
    return CNT_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/hpi_rr_pick.sv
// Combinational 2-way winner select; round-robin by default, fixed priority to
// requester 0 when ARB_FIXED_PRIO_EN is defined.
module hpi_rr_pick (
  input  logic [1:0] req,
`ifndef ARB_FIXED_PRIO_EN
  input  logic       last_gnt,
`endif
  output logic       any_c,
  output logic       winner_c
);

  always_comb begin
    any_c    = |req;
    winner_c = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
    winner_c = ~req[0];
`else
    // On contention, the requester that was not served last goes next.
    unique case (req)
      2'b01:   winner_c = 1'b0;
      2'b10:   winner_c = 1'b1;
      2'b11:   winner_c = ~last_gnt;
      default: winner_c = 1'b0;
    endcase
`endif
  end

endmodule

// File: rtl/hpi_access_arbiter.sv
// Shares one EZ-OTG HPI port between NIOS (req 0) and the keycode poller (req 1),
// sequencing SETUP/STROBE/HOLD per access. Build option: ARB_FIXED_PRIO_EN.
module hpi_access_arbiter
  import hpi_arb_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 4,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [HPI_AW-1:0] addr0,
  input  logic [HPI_AW-1:0] addr1,
  input  logic [HPI_DW-1:0] wdata0,
  input  logic [HPI_DW-1:0] wdata1,
  output logic [1:0]        ack,
  output logic [HPI_DW-1:0] rdata,
  output logic              busy,
  output logic              gnt_id,
  output logic [HPI_AW-1:0] hpi_addr,
  output logic [HPI_DW-1:0] hpi_wdata,
  input  logic [HPI_DW-1:0] hpi_rdata,
  output logic              hpi_cs_n,
  output logic              hpi_r_n,
  output logic              hpi_w_n
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  hpi_cmd_t           cmd_q, cmd_d;
  logic               gnt_d;
  logic [HPI_DW-1:0]  rdata_d;
  logic [1:0]         ack_d;
  logic               cs_n_d, r_n_d, w_n_d, busy_d;
  logic               any_c, winner_c;

  hpi_rr_pick u_pick (
    .req      (req),
`ifndef ARB_FIXED_PRIO_EN
    .last_gnt (gnt_id),
`endif
    .any_c    (any_c),
    .winner_c (winner_c)
  );

  assign hpi_addr  = cmd_q.addr;
  assign hpi_wdata = cmd_q.wdata;

  // Next state, phase counter and command latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    gnt_d   = gnt_id;
    rdata_d = rdata;

    unique case (state_q)
      IDLE: begin
        if (any_c) begin
          state_d = SETUP;
          cnt_d   = cnt_load(SETUP_CYC);
          gnt_d   = winner_c;
          cmd_d   = winner_c ? '{we: we[1], addr: addr1, wdata: wdata1}
                             : '{we: we[0], addr: addr0, wdata: wdata0};
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = STROBE;
          cnt_d   = cnt_load(STROBE_CYC);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          if (!cmd_q.we) rdata_d = hpi_rdata;
          state_d = HOLD;
          cnt_d   = cnt_load(HOLD_CYC);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so the registered pins line up with it.
    cs_n_d = (state_d == IDLE);
    r_n_d  = !((state_d == STROBE) && !cmd_d.we);
    w_n_d  = !((state_d == STROBE) && cmd_d.we);
    busy_d = (state_d != IDLE);
    ack_d  = 2'b00;
    if ((state_d == HOLD) && (cnt_d == '0)) ack_d[gnt_d] = 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cmd_q    <= '0;
      gnt_id   <= 1'b1;
      rdata    <= '0;
      ack      <= 2'b00;
      busy     <= 1'b0;
      hpi_cs_n <= 1'b1;
      hpi_r_n  <= 1'b1;
      hpi_w_n  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cmd_q    <= cmd_d;
      gnt_id   <= gnt_d;
      rdata    <= rdata_d;
      ack      <= ack_d;
      busy     <= busy_d;
      hpi_cs_n <= cs_n_d;
      hpi_r_n  <= r_n_d;
      hpi_w_n  <= w_n_d;
    end
  end

endmodule

// File: tb/tb_hpi_access_arbiter.sv
// Directed self-checking bench for hpi_access_arbiter (default timing plus a
// second instance with SETUP=2/STROBE=1/HOLD=3).
module tb_hpi_access_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req, req2, we;
  logic [1:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1, hpi_rdata;

  logic [1:0]  ack, ack2;
  logic [15:0] rdata, rdata2, hpi_wdata, hpi_wdata2;
  logic        busy, busy2, gnt_id, gnt_id2;
  logic [1:0]  hpi_addr, hpi_addr2;
  logic        hpi_cs_n, hpi_r_n, hpi_w_n;
  logic        cs2_n, r2_n, w2_n;

  int total = 0;
  int bad   = 0;

  hpi_access_arbiter dut (
    .Clk(clk), .Reset_n(rst_n), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack(ack), .rdata(rdata), .busy(busy), .gnt_id(gnt_id),
    .hpi_addr(hpi_addr), .hpi_wdata(hpi_wdata), .hpi_rdata(hpi_rdata),
    .hpi_cs_n(hpi_cs_n), .hpi_r_n(hpi_r_n), .hpi_w_n(hpi_w_n)
  );

  hpi_access_arbiter #(.SETUP_CYC(2), .STROBE_CYC(1), .HOLD_CYC(3)) dut2 (
    .Clk(clk), .Reset_n(rst_n), .req(req2), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack(ack2), .rdata(rdata2), .busy(busy2), .gnt_id(gnt_id2),
    .hpi_addr(hpi_addr2), .hpi_wdata(hpi_wdata2), .hpi_rdata(hpi_rdata),
    .hpi_cs_n(cs2_n), .hpi_r_n(r2_n), .hpi_w_n(w2_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One default-timing access: cycles 1..6 cs_n low, strobe in 2..5, ack in 6, idle in 7.
  task automatic check_access(input string tag, input logic id, input logic wr,
                              input logic [15:0] exp_rd, input logic [1:0] req_after);
    for (int c = 1; c <= 7; c++) begin
      step();
      chk($sformatf("%s c%0d cs_n", tag, c), 16'(hpi_cs_n), 16'(c <= 6 ? 1'b0 : 1'b1));
      chk($sformatf("%s c%0d r_n", tag, c), 16'(hpi_r_n),
          16'((!wr && c >= 2 && c <= 5) ? 1'b0 : 1'b1));
      chk($sformatf("%s c%0d w_n", tag, c), 16'(hpi_w_n),
          16'((wr && c >= 2 && c <= 5) ? 1'b0 : 1'b1));
      chk($sformatf("%s c%0d ack", tag, c), 16'(ack),
          16'(c == 6 ? (id ? 2'b10 : 2'b01) : 2'b00));
      chk($sformatf("%s c%0d busy", tag, c), 16'(busy), 16'(c <= 6 ? 1'b1 : 1'b0));
      if (c == 1) chk($sformatf("%s gnt_id", tag), 16'(gnt_id), 16'(id));
      if (c == 6) begin
        chk($sformatf("%s rdata", tag), rdata, exp_rd);
        req = req_after;
      end
    end
  endtask

  initial begin
    logic exp_g;
    int   p;

    rst_n = 1'b0; req = 2'b00; req2 = 2'b00; we = 2'b00;
    addr0 = 2'b00; addr1 = 2'b00; wdata0 = 16'h0; wdata1 = 16'h0; hpi_rdata = 16'h0;
    step(); step();
    chk("rst cs_n", 16'(hpi_cs_n), 16'h1);
    chk("rst r_n", 16'(hpi_r_n), 16'h1);
    chk("rst w_n", 16'(hpi_w_n), 16'h1);
    chk("rst ack", 16'(ack), 16'h0);
    chk("rst rdata", rdata, 16'h0);
    chk("rst busy", 16'(busy), 16'h0);
    chk("rst gnt_id", 16'(gnt_id), 16'h1);
    chk("rst hpi_addr", 16'(hpi_addr), 16'h0);
    chk("rst hpi_wdata", hpi_wdata, 16'h0);
    rst_n = 1'b1;

    // Single read from STATUS by requester 0.
    req = 2'b01; we = 2'b00; addr0 = 2'b11; hpi_rdata = 16'hBEEF;
    check_access("t1", 1'b0, 1'b0, 16'hBEEF, 2'b00);
    chk("t1 hpi_addr", 16'(hpi_addr), 16'h3);

    // Write to DATA by requester 1; rdata must keep the previous read.
    req = 2'b10; we = 2'b10; addr1 = 2'b00; wdata1 = 16'h1234; hpi_rdata = 16'h5555;
    check_access("t2", 1'b1, 1'b1, 16'hBEEF, 2'b00);
    chk("t2 hpi_wdata", hpi_wdata, 16'h1234);
    chk("t2 hpi_addr", 16'(hpi_addr), 16'h0);

    // Both requesting for four accesses.
    req = 2'b11; we = 2'b00; hpi_rdata = 16'h1111;
    for (int a = 0; a < 4; a++) begin
`ifdef ARB_FIXED_PRIO_EN
      exp_g = 1'b0;
`else
      exp_g = (a % 2 == 1);
`endif
      check_access($sformatf("t3 a%0d", a), exp_g, 1'b0, 16'h1111, a == 3 ? 2'b00 : 2'b11);
    end

    // Command changes and req drop mid-STROBE must not disturb the latched access.
    req = 2'b01; we = 2'b01; addr0 = 2'b01; wdata0 = 16'hAAAA;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 3) begin
        addr0 = 2'b10; wdata0 = 16'h5A5A; we = 2'b00; req = 2'b00;
      end
      if (c <= 6) begin
        chk($sformatf("t4 c%0d hpi_addr", c), 16'(hpi_addr), 16'h1);
        chk($sformatf("t4 c%0d hpi_wdata", c), hpi_wdata, 16'hAAAA);
        chk($sformatf("t4 c%0d w_n", c), 16'(hpi_w_n), 16'((c >= 2 && c <= 5) ? 1'b0 : 1'b1));
        chk($sformatf("t4 c%0d r_n", c), 16'(hpi_r_n), 16'h1);
      end
      chk($sformatf("t4 c%0d ack", c), 16'(ack), 16'(c == 6 ? 2'b01 : 2'b00));
      chk($sformatf("t4 c%0d cs_n", c), 16'(hpi_cs_n), 16'(c <= 6 ? 1'b0 : 1'b1));
    end
    chk("t4 rdata kept", rdata, 16'h1111);

    // Reset asserted during STROBE.
    req = 2'b01; we = 2'b00; addr0 = 2'b00; hpi_rdata = 16'h7777;
    step(); step(); step();
    chk("t5 pre r_n", 16'(hpi_r_n), 16'h0);
    #1 rst_n = 1'b0;
    #1;
    chk("t5 cs_n", 16'(hpi_cs_n), 16'h1);
    chk("t5 r_n", 16'(hpi_r_n), 16'h1);
    chk("t5 w_n", 16'(hpi_w_n), 16'h1);
    chk("t5 busy", 16'(busy), 16'h0);
    chk("t5 rdata", rdata, 16'h0);
    chk("t5 gnt_id", 16'(gnt_id), 16'h1);
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("t5 rst c%0d ack", c), 16'(ack), 16'h0);
      chk($sformatf("t5 rst c%0d cs_n", c), 16'(hpi_cs_n), 16'h1);
    end
    rst_n = 1'b1;
    check_access("t5 fresh", 1'b0, 1'b0, 16'h7777, 2'b00);

    // Alternate timing, two back-to-back reads on the second instance.
    req2 = 2'b01; we = 2'b00; hpi_rdata = 16'hC0DE;
    for (int c = 1; c <= 14; c++) begin
      step();
      p = (c - 1) % 7 + 1;
      chk($sformatf("t6 c%0d cs_n", c), 16'(cs2_n), 16'(p <= 6 ? 1'b0 : 1'b1));
      chk($sformatf("t6 c%0d r_n", c), 16'(r2_n), 16'(p == 3 ? 1'b0 : 1'b1));
      chk($sformatf("t6 c%0d w_n", c), 16'(w2_n), 16'h1);
      chk($sformatf("t6 c%0d ack", c), 16'(ack2), 16'(p == 6 ? 2'b01 : 2'b00));
      if (p == 6) chk($sformatf("t6 c%0d rdata", c), rdata2, 16'hC0DE);
      if (c == 13) req2 = 2'b00;
    end
    chk("t6 dut idle cs_n", 16'(hpi_cs_n), 16'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
